// File: rtl/genie_skid_fifo.sv
// genie_skid_fifo: elastic skid buffer with flop-driven ready upstream and flop-driven data/valid downstream.
// Optional high-water-mark output o_hwm is enabled by defining GENIE_SKID_FIFO_HWM_EN.
module genie_skid_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             i_data,
   input  logic                         i_valid,
   output logic                         o_ready,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
`ifdef GENIE_SKID_FIFO_HWM_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]   o_hwm
`endif
);

   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);
   localparam int AD    = DEPTH - 1;
   // DEPTH=2 needs one slot; a spare keeps the 1-bit pointer a legal index
   localparam int MEM_N = (AD < 2) ? 2 : AD;
   localparam logic [PW-1:0] PTR_LAST = PW'(AD - 1);

   // Array pointer advance with explicit wrap, since AD is not a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1'b1);
      end
      return nxt;
   endfunction

   logic [WIDTH-1:0] mem_r [MEM_N];
   logic [PW-1:0]    rd_ptr_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [WIDTH-1:0] head_r;
   logic             valid_r;
   logic             ready_r;
   logic [CW-1:0]    count_r;

   logic             push_s;
   logic             pop_s;
   logic [CW-1:0]    arr_cnt_s;
   logic             arr_ne_s;
   logic             refill_s;
   logic             load_arr_s;
   logic             bypass_s;
   logic             wr_arr_s;
   logic [CW-1:0]    count_next_s;
   logic [WIDTH-1:0] head_next_s;

   // Handshake decode, head refill selection and occupancy update
   always_comb begin
      push_s       = i_valid & ready_r;
      pop_s        = valid_r & i_ready;
      arr_cnt_s    = count_r - CW'(valid_r);
      arr_ne_s     = (arr_cnt_s != {CW{1'b0}});
      refill_s     = pop_s | ~valid_r;
      load_arr_s   = refill_s & arr_ne_s;
      bypass_s     = refill_s & ~arr_ne_s & push_s;
      wr_arr_s     = push_s & ~bypass_s;
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
      head_next_s  = head_r;
      if (load_arr_s) begin
         head_next_s = mem_r[rd_ptr_r];
      end else if (bypass_s) begin
         head_next_s = i_data;
      end else begin
         head_next_s = head_r;
      end
   end

   // Control state, head register and pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r   <= {WIDTH{1'b0}};
         valid_r  <= 1'b0;
         ready_r  <= 1'b1;
         count_r  <= {CW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
      end else begin
         head_r   <= head_next_s;
         valid_r  <= (count_next_s != {CW{1'b0}});
         ready_r  <= (count_next_s < CW'(DEPTH));
         count_r  <= count_next_s;
         if (load_arr_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         if (wr_arr_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
      end
   end

   // Storage array behind the head register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_N; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_arr_s) begin
         mem_r[wr_ptr_r] <= i_data;
      end
   end

`ifdef GENIE_SKID_FIFO_HWM_EN
   logic [CW-1:0] hwm_r;

   // High-water mark; bounded by DEPTH because count never exceeds it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hwm_r <= {CW{1'b0}};
      end else if (count_next_s > hwm_r) begin
         hwm_r <= count_next_s;
      end
   end

   assign o_hwm = hwm_r;
`endif

   assign o_ready = ready_r;
   assign o_data  = head_r;
   assign o_valid = valid_r;
   assign o_count = count_r;

endmodule

// File: tb/tb_genie_skid_fifo.sv
// Self-checking bench for genie_skid_fifo: DEPTH 4, 2 and 8 instances share stimulus,
// each compared against a queue-style occupancy model.
module tb_genie_skid_fifo;

   localparam int W  = 8;
   localparam int NI = 3;

   logic         clk;
   logic         reset;
   logic [W-1:0] i_data;
   logic         i_valid;
   logic         i_ready;

   logic         o_ready_a [NI];
   logic [W-1:0] o_data_a  [NI];
   logic         o_valid_a [NI];
   logic [2:0]   cnt0;
   logic [1:0]   cnt1;
   logic [3:0]   cnt2;
`ifdef GENIE_SKID_FIFO_HWM_EN
   logic [2:0]   hwm0;
   logic [1:0]   hwm1;
   logic [3:0]   hwm2;
`endif

   int compared;
   int mismatched;

   logic [W-1:0] mbuf  [NI][16];
   int           mhead [NI];
   int           msize [NI];
   int           mhwm  [NI];
   bit           mpush [NI];
   bit           mpop  [NI];

   genie_skid_fifo #(.WIDTH(W), .DEPTH(4)) u_d4 (
      .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready_a[0]), .o_data(o_data_a[0]), .o_valid(o_valid_a[0]),
      .i_ready(i_ready), .o_count(cnt0)
`ifdef GENIE_SKID_FIFO_HWM_EN
      , .o_hwm(hwm0)
`endif
   );

   genie_skid_fifo #(.WIDTH(W), .DEPTH(2)) u_d2 (
      .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready_a[1]), .o_data(o_data_a[1]), .o_valid(o_valid_a[1]),
      .i_ready(i_ready), .o_count(cnt1)
`ifdef GENIE_SKID_FIFO_HWM_EN
      , .o_hwm(hwm1)
`endif
   );

   genie_skid_fifo #(.WIDTH(W), .DEPTH(8)) u_d8 (
      .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready_a[2]), .o_data(o_data_a[2]), .o_valid(o_valid_a[2]),
      .i_ready(i_ready), .o_count(cnt2)
`ifdef GENIE_SKID_FIFO_HWM_EN
      , .o_hwm(hwm2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dep(input int k);
      case (k)
         0:       return 4;
         1:       return 2;
         default: return 8;
      endcase
   endfunction

   function automatic logic [31:0] cnt_of(input int k);
      case (k)
         0:       return 32'(cnt0);
         1:       return 32'(cnt1);
         default: return 32'(cnt2);
      endcase
   endfunction

`ifdef GENIE_SKID_FIFO_HWM_EN
   function automatic logic [31:0] hwm_of(input int k);
      case (k)
         0:       return 32'(hwm0);
         1:       return 32'(hwm1);
         default: return 32'(hwm2);
      endcase
   endfunction
`endif

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s depth=%0d observed=%0h expected=%0h", tag, dep(k), obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         mhead[k] = 0;
         msize[k] = 0;
         mhwm[k]  = 0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk("valid", k, 32'(o_valid_a[k]), 32'(msize[k] > 0));
         chk("ready", k, 32'(o_ready_a[k]), 32'(msize[k] < dep(k)));
         chk("count", k, cnt_of(k), 32'(msize[k]));
         if (msize[k] > 0) begin
            chk("data", k, 32'(o_data_a[k]), 32'(mbuf[k][mhead[k]]));
         end
`ifdef GENIE_SKID_FIFO_HWM_EN
         chk("hwm", k, hwm_of(k), 32'(mhwm[k]));
`endif
      end
   endtask

   // One clock: drive inputs, advance the model by the accepted push/pop, compare.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
      i_valid = v;
      i_data  = d;
      i_ready = r;
      for (int k = 0; k < NI; k++) begin
         mpush[k] = v && (msize[k] < dep(k));
         mpop[k]  = r && (msize[k] > 0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         if (mpop[k]) begin
            mhead[k] = (mhead[k] + 1) % 16;
            msize[k] = msize[k] - 1;
         end
         if (mpush[k]) begin
            mbuf[k][(mhead[k] + msize[k]) % 16] = d;
            msize[k] = msize[k] + 1;
         end
         if (msize[k] > mhwm[k]) mhwm[k] = msize[k];
      end
      check_all();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      i_valid    = 1'b0;
      i_data     = '0;
      i_ready    = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_all();
      for (int k = 0; k < NI; k++) chk("rst_data", k, 32'(o_data_a[k]), 32'h0);
      reset = 1'b1;

      // Idle after release
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);

      // Fill to three, then asynchronous reset mid-stream
      cycle(1'b1, 8'h21, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      cycle(1'b1, 8'h23, 1'b0);
      chk("pre_rst_count", 0, 32'(cnt0), 32'd3);
`ifdef GENIE_SKID_FIFO_HWM_EN
      chk("pre_rst_hwm", 0, 32'(hwm0), 32'd3);
`endif
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < NI; k++) begin
         chk("async_valid", k, 32'(o_valid_a[k]), 32'd0);
         chk("async_count", k, cnt_of(k), 32'd0);
`ifdef GENIE_SKID_FIFO_HWM_EN
         chk("async_hwm", k, hwm_of(k), 32'd0);
`endif
      end
      #2;
      reset = 1'b1;

      // Single-cycle fall-through
      cycle(1'b1, 8'h11, 1'b1);
      chk("lat_data", 0, 32'(o_data_a[0]), 32'h11);
      chk("lat_valid", 0, 32'(o_valid_a[0]), 32'd1);
      cycle(1'b0, 8'h00, 1'b1);

      // Continuous stream at occupancy 1
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, W'(i), 1'b1);
         chk("stream_count", 0, 32'(cnt0), 32'd1);
      end
      cycle(1'b0, 8'h00, 1'b1);

      // Fill to full, dropped word, full-to-not-full ready
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + W'(i), 1'b0);
      chk("full_count", 0, 32'(cnt0), 32'd4);
      chk("full_ready", 0, 32'(o_ready_a[0]), 32'd0);
      cycle(1'b1, 8'hFF, 1'b0);
      chk("drop_count", 0, 32'(cnt0), 32'd4);
      chk("drop_head", 0, 32'(o_data_a[0]), 32'hA0);
      cycle(1'b0, 8'h00, 1'b1);
      chk("unfull_ready", 0, 32'(o_ready_a[0]), 32'd1);
      chk("unfull_head", 0, 32'(o_data_a[0]), 32'hA1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);

      // Push with pop at count two
      cycle(1'b1, 8'h01, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h55, 1'b1);
      chk("pp_count", 0, 32'(cnt0), 32'd2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

      // Toggling ready under mostly-continuous valid
      for (int c = 0; c < 400; c++) begin
         cycle(1'($urandom_range(0, 3) != 0), W'($urandom), c[0]);
      end
      // Fully random handshakes
      for (int c = 0; c < 400; c++) begin
         cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)));
      end

      // Drain
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < NI; k++) chk("final_count", k, cnt_of(k), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
